// File: rtl/npu_pool_pkg.sv
// Shared types and helpers for the ReLU + 2x2 max-pool writer.
// Optional feature macro: RELU_MAXPOOL_RELU_EN (defined -> negative values clamp to 0).
package npu_pool_pkg;

  // Frame-level control states of the writer FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default pixel width; the helper functions below operate on this width.
  localparam int DATA_W_DEF = 8;

  // Signed maximum of two pixels.
  function automatic logic signed [DATA_W_DEF-1:0] smax(
    input logic signed [DATA_W_DEF-1:0] a,
    input logic signed [DATA_W_DEF-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Rectifier; identity when the ReLU feature is not built in.
  function automatic logic signed [DATA_W_DEF-1:0] relu(
    input logic signed [DATA_W_DEF-1:0] x
  );
`ifdef RELU_MAXPOOL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the horizontal maxima of the most recent even conv row.
// One synchronous write port, one asynchronous read port, both indexed by k.
module pool_line_buf #(
  parameter int DEPTH  = 13,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Register array: cleared on reset, written one entry per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_we) begin
      mem_q[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_ridx];

endmodule

// File: rtl/relu_maxpool_writer.sv
// ReLU + 2x2 max-pool stage writing pooled pixels to the output feature-map RAM.
// Optional feature macro: RELU_MAXPOOL_RELU_EN (clamps negative pixels before pooling).
//
// Handshake: a beat transfers on a rising edge where i_valid && o_ready and
// i_start is low; o_ready depends only on registered state, never on i_valid.
module relu_maxpool_writer
  import npu_pool_pkg::*;
#(
  parameter int CONV_COLS = 26,
  parameter int CONV_ROWS = 26,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_sum1,
  input  logic [DATA_W-1:0] i_sum2,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  localparam int HALF     = CONV_COLS / 2;
  localparam int K_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int R_W      = (CONV_ROWS > 1) ? $clog2(CONV_ROWS) : 1;
  localparam int K_LAST   = HALF - 1;
  // Last row that completes a pooled row; an odd trailing row is never consumed.
  localparam int LAST_ROW = 2 * (CONV_ROWS / 2) - 1;

  state_t            state_q;
  logic [K_W-1:0]    k_q;
  logic [R_W-1:0]    row_q;
  logic [ADDR_W-1:0] base_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;

  logic              accept;
  logic              odd_row;
  logic              last_k;
  logic              last_beat;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] buf_rdata;
  logic [DATA_W-1:0] pooled_d;
  logic [ADDR_W-1:0] prow_off;
  logic [ADDR_W-1:0] wr_addr_d;

  // Beat acceptance, horizontal/vertical pooling and address generation.
  always_comb begin
    accept    = i_valid && (state_q == RUN) && !i_start;
    odd_row   = row_q[0];
    last_k    = (k_q == K_W'(K_LAST));
    last_beat = last_k && (row_q == R_W'(LAST_ROW));
    h_max     = smax(relu(i_sum1), relu(i_sum2));
    pooled_d  = smax(buf_rdata, h_max);
    prow_off  = ADDR_W'(row_q >> 1) * ADDR_W'(HALF);
    wr_addr_d = base_q + prow_off + ADDR_W'(k_q);
  end

  // Even rows park their horizontal maxima here; odd rows read them back.
  pool_line_buf #(
    .DEPTH (HALF),
    .DATA_W(DATA_W),
    .IDX_W (K_W)
  ) u_line_buf (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_we   (accept && !odd_row),
    .i_widx (k_q),
    .i_wdata(h_max),
    .i_ridx (k_q),
    .o_rdata(buf_rdata)
  );

  // Frame FSM with counters and registered RAM write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      row_q     <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (i_start) begin
        // Start or restart: stale line-buffer data is overwritten by row 0.
        state_q <= RUN;
        k_q     <= '0;
        row_q   <= '0;
        base_q  <= i_dst_base;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (accept) begin
              if (odd_row) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wr_addr_d;
                wr_data_q <= pooled_d;
              end
              if (last_k) begin
                k_q   <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                k_q <= k_q + 1'b1;
              end
              if (last_beat) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          IDLE:    state_q <= IDLE;
          DONE:    state_q <= DONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_ready     = (state_q == RUN);
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule
